// File: rtl/instr_encoder_if.sv
// instr_encoder_if: command channel into the MIPS instruction encoder.
// Carries a valid/ready handshake with the command class and the raw instruction fields.
//   cmd_valid  command present (master -> slave)
//   cmd_ready  encoder can accept (slave -> master)
//   cmd_kind   0=R 1=lw 2=sw 3=beq 4=addi 5=j 6=END 7=illegal
//   cmd_rs/rt/rd, cmd_funct, cmd_imm  instruction fields
interface instr_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_kind;
   logic [4:0]  cmd_rs;
   logic [4:0]  cmd_rt;
   logic [4:0]  cmd_rd;
   logic [5:0]  cmd_funct;
   logic [25:0] cmd_imm;
   modport master (output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_funct, cmd_imm, input cmd_ready);
   modport slave (input cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_funct, cmd_imm, output cmd_ready);
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: assembles command-channel instructions into MIPS words and writes them to
// consecutive imem addresses, for loading a program before the core leaves reset.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begins a load session at address 0 (ignored while loading)
//   cmd          command channel (slave side)
//   imem_we/addr/wd  registered instruction-memory write port
//   count        words written this session
//   busy, done, err  loading / session finished / finished on an illegal command
module instr_encoder #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   instr_encoder_if.slave    cmd,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wd,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   // count value just before the DEPTH-th word is written
   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
   state_t      state;
   logic [5:0]  op;
   logic [31:0] word;
   assign cmd.cmd_ready = state == LOAD;
   assign busy = state == LOAD;
   assign done = state == DONE;
   always_comb begin
      op = cmd.cmd_kind == 3'd0 ? 6'b000000 :
           cmd.cmd_kind == 3'd1 ? 6'b100011 :
           cmd.cmd_kind == 3'd2 ? 6'b101011 :
           cmd.cmd_kind == 3'd3 ? 6'b000100 :
           cmd.cmd_kind == 3'd4 ? 6'b001000 : 6'b000010;
      word = cmd.cmd_kind == 3'd0 ? {op, cmd.cmd_rs, cmd.cmd_rt, cmd.cmd_rd, 5'b00000, cmd.cmd_funct} :
             cmd.cmd_kind == 3'd5 ? {op, cmd.cmd_imm} :
                                    {op, cmd.cmd_rs, cmd.cmd_rt, cmd.cmd_imm[15:0]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         imem_we   <= 1'b0;
         imem_addr <= '0;
         imem_wd   <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (state != LOAD) begin
            if (start) begin
               state <= LOAD;
               count <= '0;
               err   <= 1'b0;
            end
         end else if (cmd.cmd_valid) begin
            if (cmd.cmd_kind < 3'd6) begin
               imem_we   <= 1'b1;
               imem_addr <= count[ADDR_W-1:0];
               imem_wd   <= word;
               count     <= count + 1'b1;
               // memory full: stop taking commands so the address never wraps
               if (count == LAST)
                  state <= DONE;
            end else begin
               state <= DONE;
               err   <= cmd.cmd_kind == 3'd7;
            end
         end
      end
   end
endmodule
